pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the IF/ID, ID/EX and EX/MEM pipeline registers.
// Covers load-use stalls, taken-branch flushes and multi-cycle EX handshakes, and keeps performance counters.
module pipe_hazard_ctrl #(
   parameter int CNT_W      = 16,
   parameter int MC_TIMEOUT = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             id_uses_rt_i,
   input  logic [4:0]       ex_rt_i,
   input  logic             ex_mem_read_i,
   input  logic             br_taken_i,
   input  logic             mc_start_i,
   input  logic             mc_done_i,
   output logic             pc_we_o,
   output logic             ifid_we_o,
   output logic             ifid_flush_o,
   output logic             idex_we_o,
   output logic             idex_flush_o,
   output logic             exmem_flush_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             mc_err_o
);

   localparam int TO_W = $clog2(MC_TIMEOUT + 1);

   typedef enum logic {RUN, MC_WAIT} state_t;

   state_t            state_q, state_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              mc_err_q, mc_err_d;
   logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

   logic lu;
   logic to_hit;
   logic flush_evt;
   logic pc_we_c, ifid_we_c, ifid_flush_c, idex_we_c, idex_flush_c, exmem_flush_c;

   // Register zero is hard-wired, so a load targeting it never creates a dependency.
   assign lu = ex_mem_read_i && (ex_rt_i != 5'd0) &&
               ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

   assign to_hit = (state_q == MC_WAIT) && !mc_done_i && (to_cnt_q == TO_W'(MC_TIMEOUT));

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
      pc_we_c       = 1'b1;
      ifid_we_c     = 1'b1;
      ifid_flush_c  = 1'b0;
      idex_we_c     = 1'b1;
      idex_flush_c  = 1'b0;
      exmem_flush_c = 1'b0;
      flush_evt     = 1'b0;
      state_d       = state_q;
      to_cnt_d      = to_cnt_q;
      mc_err_d      = mc_err_q;

      case (state_q)
         RUN: begin
            if (mc_start_i) begin
               pc_we_c       = 1'b0;
               ifid_we_c     = 1'b0;
               idex_we_c     = 1'b0;
               exmem_flush_c = 1'b1;
               state_d       = MC_WAIT;
               to_cnt_d      = TO_W'(1);
            end else if (br_taken_i) begin
               ifid_flush_c = 1'b1;
               idex_flush_c = 1'b1;
               flush_evt    = 1'b1;
            end else if (lu) begin
               // One bubble into ID/EX; next cycle EX holds a non-load and the hazard clears itself.
               pc_we_c      = 1'b0;
               ifid_we_c    = 1'b0;
               idex_flush_c = 1'b1;
            end
         end

         MC_WAIT: begin
            if (mc_done_i) begin
               state_d  = RUN;
               to_cnt_d = '0;
            end else if (to_hit) begin
               // Abort releases the pipeline exactly like a done cycle, but records the error.
               mc_err_d = 1'b1;
               state_d  = RUN;
               to_cnt_d = '0;
            end else begin
               pc_we_c       = 1'b0;
               ifid_we_c     = 1'b0;
               idex_we_c     = 1'b0;
               exmem_flush_c = 1'b1;
               to_cnt_d      = to_cnt_q + TO_W'(1);
            end
         end

         default: begin
            state_d  = RUN;
            to_cnt_d = '0;
         end
      endcase
   end

   // Controls are forced low for as long as reset is held, independent of the clock.
   assign pc_we_o       = rst_i & pc_we_c;
   assign ifid_we_o     = rst_i & ifid_we_c;
   assign ifid_flush_o  = rst_i & ifid_flush_c;
   assign idex_we_o     = rst_i & idex_we_c;
   assign idex_flush_o  = rst_i & idex_flush_c;
   assign exmem_flush_o = rst_i & exmem_flush_c;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= RUN;
         to_cnt_q    <= '0;
         mc_err_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q  <= state_d;
         to_cnt_q <= to_cnt_d;
         mc_err_q <= mc_err_d;
         if (!pc_we_c && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_evt && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
   assign mc_err_o    = mc_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

   localparam int CNT_W  = 4;
   localparam int MC_TO  = 8;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic [4:0]       id_rs_i = '0, id_rt_i = '0, ex_rt_i = '0;
   logic             id_uses_rt_i = 1'b0, ex_mem_read_i = 1'b0;
   logic             br_taken_i = 1'b0, mc_start_i = 1'b0, mc_done_i = 1'b0;
   logic             pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_flush_o, exmem_flush_o;
   logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
   logic             mc_err_o;

   int vectors     = 0;
   int miscompares = 0;

   // Model state: whether an EX op is outstanding, how many wait cycles so far, counters.
   bit         m_wait;
   int         m_wait_n;
   bit         m_err;
   int         m_stall, m_flush;
   bit         m_go_wait, m_leave, m_abort, m_evt_flush;
   logic [5:0] exp_ctl;   // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush}

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .MC_TIMEOUT(MC_TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
      .ex_rt_i(ex_rt_i), .ex_mem_read_i(ex_mem_read_i),
      .br_taken_i(br_taken_i), .mc_start_i(mc_start_i), .mc_done_i(mc_done_i),
      .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o), .ifid_flush_o(ifid_flush_o),
      .idex_we_o(idex_we_o), .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .mc_err_o(mc_err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [5:0] ctl_now();
      return {pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_flush_o, exmem_flush_o};
   endfunction

   task automatic model_reset();
      m_wait = 0; m_wait_n = 0; m_err = 0; m_stall = 0; m_flush = 0;
   endtask

   // Drive one cycle's inputs after the falling edge and derive the expected controls.
   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic [4:0] ert, input logic mr, input logic br,
                        input logic ms, input logic md);
      bit lu;
      @(negedge clk_i);
      id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = urt; ex_rt_i = ert;
      ex_mem_read_i = mr; br_taken_i = br; mc_start_i = ms; mc_done_i = md;
      #1;
      lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
      m_go_wait = 0; m_leave = 0; m_abort = 0; m_evt_flush = 0;
      if (!m_wait) begin
         if (ms)      begin exp_ctl = 6'b000001; m_go_wait = 1; end
         else if (br) begin exp_ctl = 6'b111110; m_evt_flush = 1; end
         else if (lu) exp_ctl = 6'b000110;
         else         exp_ctl = 6'b110100;
      end else if (md) begin
         exp_ctl = 6'b110100; m_leave = 1;
      end else if (m_wait_n == MC_TO) begin
         exp_ctl = 6'b110100; m_leave = 1; m_abort = 1;
      end else begin
         exp_ctl = 6'b000001;
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      if (!exp_ctl[5] && m_stall < CMAX) m_stall++;
      if (m_evt_flush && m_flush < CMAX) m_flush++;
      if (m_abort) m_err = 1;
      if (m_go_wait) begin m_wait = 1; m_wait_n = 1; end
      else if (m_leave) m_wait = 0;
      else if (m_wait) m_wait_n++;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      {id_rs_i, id_rt_i, ex_rt_i} = '0;
      {id_uses_rt_i, ex_mem_read_i, br_taken_i, mc_start_i, mc_done_i} = '0;
      @(negedge clk_i);
      rst_i = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      #12;
      vectors++;
      if (ctl_now() !== 6'b000000) begin miscompares++; $display("FAIL reset_ctl got %b exp 000000", ctl_now()); end
      vectors++;
      if ({stall_cnt_o, flush_cnt_o, mc_err_o} !== '0) begin
         miscompares++; $display("FAIL reset_state stall=%0d flush=%0d err=%b exp all 0", stall_cnt_o, flush_cnt_o, mc_err_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (ctl_now() !== 6'b110100) begin miscompares++; $display("FAIL reset_release got %b exp 110100", ctl_now()); end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(5, 0, 0, 5, 1, 0, 0, 0);
      vectors++;
      if (ctl_now() !== 6'b000110) begin miscompares++; $display("FAIL lu_stall got %b exp 000110", ctl_now()); end
      tick();
      drive(5, 0, 0, 5, 0, 0, 0, 0);
      vectors++;
      if (ctl_now() !== 6'b110100) begin miscompares++; $display("FAIL lu_release got %b exp 110100", ctl_now()); end
      vectors++;
      if (stall_cnt_o !== 4'd1) begin miscompares++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt_o); end
      tick();
      // rt dependency counts only when the ID instruction actually reads rt
      drive(3, 7, 1, 7, 1, 0, 0, 0);
      vectors++;
      if (ctl_now() !== 6'b000110) begin miscompares++; $display("FAIL lu_rt got %b exp 000110", ctl_now()); end
      tick();
      drive(3, 7, 0, 7, 1, 0, 0, 0);
      vectors++;
      if (ctl_now() !== 6'b110100) begin miscompares++; $display("FAIL lu_rt_unused got %b exp 110100", ctl_now()); end
      tick();
   endtask

   task automatic test_reg_zero();
      do_reset();
      drive(0, 0, 1, 0, 1, 0, 0, 0);
      vectors++;
      if (ctl_now() !== 6'b110100) begin miscompares++; $display("FAIL reg_zero got %b exp 110100", ctl_now()); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (stall_cnt_o !== 4'd0) begin miscompares++; $display("FAIL reg_zero_cnt got %0d exp 0", stall_cnt_o); end
      tick();
   endtask

   task automatic test_branch_lu();
      do_reset();
      drive(5, 0, 0, 5, 1, 1, 0, 0);
      vectors++;
      if (ctl_now() !== 6'b111110) begin miscompares++; $display("FAIL br_lu got %b exp 111110", ctl_now()); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if ({flush_cnt_o, stall_cnt_o} !== {4'd1, 4'd0}) begin
         miscompares++; $display("FAIL br_lu_cnt flush=%0d stall=%0d exp 1/0", flush_cnt_o, stall_cnt_o);
      end
      tick();
   endtask

   task automatic test_multicycle();
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      vectors++;
      if (ctl_now() !== 6'b000001) begin miscompares++; $display("FAIL mc_start got %b exp 000001", ctl_now()); end
      tick();
      for (int i = 0; i < 3; i++) begin
         // branch and load-use inputs present during the wait must be ignored
         drive(5, 0, 0, 5, 1, i[0], 0, 0);
         vectors++;
         if (ctl_now() !== 6'b000001) begin miscompares++; $display("FAIL mc_wait%0d got %b exp 000001", i, ctl_now()); end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      vectors++;
      if (ctl_now() !== 6'b110100) begin miscompares++; $display("FAIL mc_done got %b exp 110100", ctl_now()); end
      tick();
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      vectors++;
      if (ctl_now() !== 6'b111110) begin miscompares++; $display("FAIL mc_back_in_run got %b exp 111110", ctl_now()); end
      vectors++;
      if ({stall_cnt_o, mc_err_o} !== {4'd4, 1'b0}) begin
         miscompares++; $display("FAIL mc_cnt stall=%0d err=%b exp 4/0", stall_cnt_o, mc_err_o);
      end
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      for (int i = 1; i < MC_TO; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         vectors++;
         if (ctl_now() !== 6'b000001) begin miscompares++; $display("FAIL to_wait%0d got %b exp 000001", i, ctl_now()); end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if ({ctl_now(), mc_err_o} !== {6'b110100, 1'b0}) begin
         miscompares++; $display("FAIL to_abort got %b err=%b exp 110100 err=0", ctl_now(), mc_err_o);
      end
      tick();
      drive(5, 0, 0, 5, 1, 0, 0, 0);
      vectors++;
      if ({ctl_now(), mc_err_o, stall_cnt_o} !== {6'b000110, 1'b1, 4'd8}) begin
         miscompares++; $display("FAIL to_after got %b err=%b stall=%0d exp 000110 1 8", ctl_now(), mc_err_o, stall_cnt_o);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (mc_err_o !== 1'b1) begin miscompares++; $display("FAIL to_sticky got %b exp 1", mc_err_o); end
      tick();
      do_reset();
      vectors++;
      if (mc_err_o !== 1'b0) begin miscompares++; $display("FAIL to_cleared got %b exp 0", mc_err_o); end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      @(negedge clk_i);
      mc_done_i = 1'b1;
      #1;
      vectors++;
      if (ctl_now() !== 6'b110100) begin miscompares++; $display("FAIL ar_pre got %b exp 110100", ctl_now()); end
      #1;
      rst_i = 1'b0;
      #1;
      vectors++;
      if (ctl_now() !== 6'b000000) begin miscompares++; $display("FAIL ar_ctl got %b exp 000000", ctl_now()); end
      vectors++;
      if ({stall_cnt_o, flush_cnt_o, mc_err_o} !== '0) begin
         miscompares++; $display("FAIL ar_cnt stall=%0d flush=%0d err=%b exp 0", stall_cnt_o, flush_cnt_o, mc_err_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      model_reset();
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      vectors++;
      if (ctl_now() !== 6'b111110) begin miscompares++; $display("FAIL ar_run got %b exp 111110", ctl_now()); end
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < CMAX + 5; i++) begin
         drive(9, 0, 0, 9, 1, 0, 0, 0);
         tick();
      end
      for (int i = 0; i < CMAX + 5; i++) begin
         drive(0, 0, 0, 0, 0, 1, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if ({stall_cnt_o, flush_cnt_o} !== {4'(CMAX), 4'(CMAX)}) begin
         miscompares++; $display("FAIL saturate stall=%0d flush=%0d exp %0d", stall_cnt_o, flush_cnt_o, CMAX);
      end
      tick();
   endtask

   task automatic test_random();
      logic [4:0] rs, rt, ert;
      logic urt, mr, br, ms, md;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (i % 80 == 79) do_reset();
         rs  = 5'($urandom_range(0, 3));
         rt  = 5'($urandom_range(0, 3));
         ert = 5'($urandom_range(0, 3));
         urt = 1'($urandom);
         mr  = 1'($urandom_range(0, 2) == 0);
         br  = 1'($urandom_range(0, 5) == 0);
         ms  = 1'($urandom_range(0, 9) == 0);
         md  = 1'($urandom_range(0, 5) == 0);
         if (ms && !m_wait) br = 1'b0;
         drive(rs, rt, urt, ert, mr, br, ms, md);
         vectors++;
         if ({ctl_now(), stall_cnt_o, flush_cnt_o, mc_err_o} !==
             {exp_ctl, 4'(m_stall), 4'(m_flush), m_err}) begin
            miscompares++;
            $display("FAIL rand[%0d] ctl=%b s=%0d f=%0d e=%b exp ctl=%b s=%0d f=%0d e=%b",
                     i, ctl_now(), stall_cnt_o, flush_cnt_o, mc_err_o, exp_ctl, m_stall, m_flush, m_err);
         end
         tick();
      end
   endtask

   initial begin
      model_reset();
      exp_ctl = '0;
      test_reset();
      test_load_use();
      test_reg_zero();
      test_branch_lu();
      test_multicycle();
      test_timeout();
      test_async_reset();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
